// File: rtl/data_access_ctrl_pkg.sv
// Shared widths and FSM state encodings for the data access controller.
// Optional statistics counters are enabled with DATA_ACC_STATS_EN.
package data_access_ctrl_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_DATA_ADDR_WIDTH = 4;
  localparam int DEF_CNT_WIDTH       = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR1  = 3'd1,
    ST_WR2  = 3'd2,
    ST_RD1  = 3'd3,
    ST_RD2  = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

endpackage

// File: rtl/data_access_ctrl_if.sv
// Client request/response and register-file signals of the data access controller.
// Count outputs exist only when DATA_ACC_STATS_EN is defined.
interface data_access_ctrl_if
  import data_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DATA_ADDR_WIDTH = DEF_DATA_ADDR_WIDTH
`ifdef DATA_ACC_STATS_EN
  ,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
`endif
);

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_wr;
  logic [DATA_ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]      req_wdata;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic [DATA_WIDTH-1:0]      rf_data_in;
  logic [DATA_ADDR_WIDTH-1:0] rf_address;
  logic                       rf_mode;
  logic [DATA_WIDTH-1:0]      rf_data_out;
`ifdef DATA_ACC_STATS_EN
  logic [CNT_WIDTH-1:0]       wr_count;
  logic [CNT_WIDTH-1:0]       rd_count;
`endif

  // Controller side
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, rf_data_out,
    output req_ready, rsp_valid, rsp_rdata, rf_data_in, rf_address, rf_mode
`ifdef DATA_ACC_STATS_EN
    , output wr_count, rd_count
`endif
  );

  // Client plus register-file side
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready, rf_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rf_data_in, rf_address, rf_mode
`ifdef DATA_ACC_STATS_EN
    , input wr_count, rd_count
`endif
  );

endinterface

// File: rtl/data_access_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high clear.
// Used for the DATA_ACC_STATS_EN statistics.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/data_access_ctrl.sv
// Request sequencer in front of the data register file: hides its input registration
// and two-edge write commit. Statistics counters enabled by DATA_ACC_STATS_EN.
module data_access_ctrl
  import data_access_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DATA_ADDR_WIDTH = DEF_DATA_ADDR_WIDTH
`ifdef DATA_ACC_STATS_EN
  ,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
`endif
) (
  input logic               clk,
  input logic               rst,
  data_access_ctrl_if.slave bus
);

  state_t                     r_state;
  logic [DATA_WIDTH-1:0]      r_rf_data_in;
  logic [DATA_ADDR_WIDTH-1:0] r_rf_address;
  logic                       r_rf_mode;
  logic                       r_rsp_valid;
  logic [DATA_WIDTH-1:0]      r_rsp_rdata;
  logic                       w_req_ready;
  logic                       w_accept;

  assign w_req_ready = (r_state == ST_IDLE) & ~rst;
  assign w_accept    = bus.req_valid & w_req_ready;

  // Address and write data stay put from accept until the register file commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rf_data_in <= '0;
      r_rf_address <= '0;
      r_rf_mode    <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rf_address <= bus.req_addr;
            if (bus.req_wr) begin
              r_rf_data_in <= bus.req_wdata;
              r_rf_mode    <= 1'b1;
              r_state      <= ST_WR1;
            end else begin
              r_state      <= ST_RD1;
            end
          end
        end
        ST_WR1: begin
          r_rf_mode <= 1'b0;
          r_state   <= ST_WR2;
        end
        ST_WR2: r_state <= ST_IDLE;
        ST_RD1: r_state <= ST_RD2;
        ST_RD2: begin
          r_rsp_rdata <= bus.rf_data_out;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RSP;
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rf_mode   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_rdata  = r_rsp_rdata;
  assign bus.rf_data_in = r_rf_data_in;
  assign bus.rf_address = r_rf_address;
  assign bus.rf_mode    = r_rf_mode;

`ifdef DATA_ACC_STATS_EN
  logic w_wr_done;
  logic w_rd_done;

  assign w_wr_done = (r_state == ST_WR2);
  assign w_rd_done = (r_state == ST_RSP) & bus.rsp_ready;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_wr_done),
    .o_count (bus.wr_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_rd_done),
    .o_count (bus.rd_count)
  );
`endif

endmodule

// File: tb/tb_data_access_ctrl.sv
// Directed self-checking bench for data_access_ctrl with a behavioural register file.
// Statistics checks run when DATA_ACC_STATS_EN is defined (counters built 2 bits wide).
module tb_data_access_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef DATA_ACC_STATS_EN
  localparam int CW = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   failCount  = 0;

  always #5 clk = ~clk;

`ifdef DATA_ACC_STATS_EN
  data_access_ctrl_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();
  data_access_ctrl #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`else
  data_access_ctrl_if #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) bus ();
  data_access_ctrl #(.DATA_WIDTH(DW), .DATA_ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`endif

  // Register file: inputs registered on one edge, write stored on the next.
  logic [DW-1:0] rfMem [16];
  logic [AW-1:0] rfAddrQ;
  logic          rfModeQ;
  logic [DW-1:0] rfDataQ;

  always @(posedge clk) begin
    if (rfModeQ) rfMem[rfAddrQ] <= rfDataQ;
    rfAddrQ <= bus.rf_address;
    rfModeQ <= bus.rf_mode;
    rfDataQ <= bus.rf_data_in;
  end

  assign bus.rf_data_out = rfMem[rfAddrQ];

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one request across a single rising edge, then withdraws it.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    stepCycle();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rfMem[i] = 8'h10 + 8'(i);
    rfAddrQ = '0;
    rfModeQ = 1'b0;
    rfDataQ = '0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    stepCycle();
    stepCycle();
    checkOutput("rst_rf_mode", bus.rf_mode, 0);
    checkOutput("rst_rf_address", bus.rf_address, 0);
    checkOutput("rst_rf_data_in", bus.rf_data_in, 0);
    checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
    checkOutput("rst_req_ready", bus.req_ready, 0);
`ifdef DATA_ACC_STATS_EN
    checkOutput("rst_wr_count", bus.wr_count, 0);
    checkOutput("rst_rd_count", bus.rd_count, 0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("rel_req_ready", bus.req_ready, 1);

    // Write addr 3 / 0xA5
    applyStimulus(1'b1, 4'd3, 8'hA5);
    checkOutput("wr_e0_mode", bus.rf_mode, 1);
    checkOutput("wr_e0_addr", bus.rf_address, 3);
    checkOutput("wr_e0_data", bus.rf_data_in, 8'hA5);
    checkOutput("wr_e0_ready", bus.req_ready, 0);
    stepCycle();
    checkOutput("wr_e1_mode", bus.rf_mode, 0);
    checkOutput("wr_e1_addr", bus.rf_address, 3);
    checkOutput("wr_e1_data", bus.rf_data_in, 8'hA5);
    checkOutput("wr_e1_ready", bus.req_ready, 0);
    stepCycle();
    checkOutput("wr_e2_ready", bus.req_ready, 1);
    checkOutput("wr_e2_addr", bus.rf_address, 3);
    checkOutput("wr_e2_data", bus.rf_data_in, 8'hA5);
    checkOutput("wr_e2_rsp_valid", bus.rsp_valid, 0);

    // Read-after-write on addr 5
    applyStimulus(1'b1, 4'd5, 8'h3C);
    stepCycle();
    stepCycle();
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b0, 4'd5, 8'hEE);
    checkOutput("raw_e0_addr", bus.rf_address, 5);
    checkOutput("raw_e0_keep_data", bus.rf_data_in, 8'h3C);
    checkOutput("raw_e0_mode", bus.rf_mode, 0);
    checkOutput("raw_e0_rsp_valid", bus.rsp_valid, 0);
    stepCycle();
    checkOutput("raw_e1_rsp_valid", bus.rsp_valid, 0);
    stepCycle();
    checkOutput("raw_e2_rsp_valid", bus.rsp_valid, 1);
    checkOutput("raw_e2_rdata", bus.rsp_rdata, 8'h3C);
    stepCycle();
    checkOutput("raw_done_rsp_valid", bus.rsp_valid, 0);
    checkOutput("raw_done_ready", bus.req_ready, 1);

    // Backpressure on a read of addr 3, with a request ignored while busy
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 4'd3, 8'h00);
    stepCycle();
    stepCycle();
    checkOutput("bp_rsp_valid", bus.rsp_valid, 1);
    checkOutput("bp_rdata", bus.rsp_rdata, 8'hA5);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 4'd7;
    bus.req_wdata = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("bp_hold_valid", bus.rsp_valid, 1);
      checkOutput("bp_hold_rdata", bus.rsp_rdata, 8'hA5);
      checkOutput("bp_hold_ready", bus.req_ready, 0);
      checkOutput("bp_hold_mode", bus.rf_mode, 0);
      checkOutput("bp_hold_addr", bus.rf_address, 3);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    stepCycle();
    checkOutput("bp_release_valid", bus.rsp_valid, 0);
    checkOutput("bp_release_ready", bus.req_ready, 1);
    checkOutput("bp_ignored_data", bus.rf_data_in, 8'h3C);

    // Reset asserted mid-cycle while a read of addr 9 sits in RD2
    applyStimulus(1'b0, 4'd9, 8'h00);
    stepCycle();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 0);
    checkOutput("mid_rst_ready", bus.req_ready, 0);
    checkOutput("mid_rst_addr", bus.rf_address, 0);
    checkOutput("mid_rst_data", bus.rf_data_in, 0);
    checkOutput("mid_rst_mode", bus.rf_mode, 0);
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkOutput("post_rst_rsp_valid", bus.rsp_valid, 0);
      checkOutput("post_rst_ready", bus.req_ready, 1);
    end
    applyStimulus(1'b0, 4'd0, 8'h00);
    stepCycle();
    stepCycle();
    checkOutput("rd0_rsp_valid", bus.rsp_valid, 1);
    checkOutput("rd0_rdata", bus.rsp_rdata, 8'h10);
    stepCycle();
    checkOutput("rd0_done_valid", bus.rsp_valid, 0);

`ifdef DATA_ACC_STATS_EN
    // Counters: 5 writes saturate a 2-bit count, 2 reads do not
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("st_clr_wr", bus.wr_count, 0);
    checkOutput("st_clr_rd", bus.rd_count, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'(10 + i), 8'h50 + 8'(i));
      stepCycle();
      stepCycle();
    end
    checkOutput("st_wr_sat", bus.wr_count, 3);
    checkOutput("st_rd_zero", bus.rd_count, 0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'(10 + i), 8'h00);
      stepCycle();
      stepCycle();
      checkOutput("st_rd_data", bus.rsp_rdata, 8'h50 + 32'(i));
      stepCycle();
    end
    checkOutput("st_wr_final", bus.wr_count, 3);
    checkOutput("st_rd_final", bus.rd_count, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
